// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and arithmetic constants for the MLP layer datapath
package mlp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_OUT,
    S_DONE
  } state_t;

  localparam int ACT_W = 16;
  localparam int WGT_W = 8;
  localparam int ACC_W = 16;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 16'sh7fff;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/bias_relu_sat.sv
// rtl/bias_relu_sat.sv - combinational bias add with signed saturation and optional ReLU
module bias_relu_sat
  import mlp_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] bias,
  output logic signed [ACC_W-1:0] y
);

  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] sat;

  always_comb begin
    sum = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    // overflow shows up as disagreement between the two top bits of the widened sum
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat = sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum[ACC_W-1:0];
    end
    y = (RELU && sat[ACC_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dense-layer MAC controller: operand streaming, drain, bias/ReLU, result handshake
module mac_sequencer
  import mlp_pkg::*;
#(
  parameter int N_INPUTS  = 16,
  parameter int N_NEURONS = 8,
  parameter int MAC_LAT   = 1,
  parameter bit RELU      = 1'b1,
  localparam int IW = $clog2(N_INPUTS),
  localparam int WW = $clog2(N_INPUTS * N_NEURONS),
  localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [IW-1:0]           in_addr,
  output logic [WW-1:0]           w_addr,
  output logic [NW-1:0]           bias_addr,
  input  logic signed [ACC_W-1:0] bias_data,
  output logic                    mac_en,
  output logic                    mac_first,
  input  logic signed [ACC_W-1:0] mac_acc,
  output logic signed [ACC_W-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [NW-1:0]           neuron_idx
);

  localparam int DW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  state_t                  state, state_n;
  logic [IW-1:0]           k, k_n;
  logic [NW-1:0]           neuron, neuron_n;
  logic [WW-1:0]           w, w_n;
  logic [DW-1:0]           d, d_n;
  logic                    capture;
  logic                    k_last, n_last;
  logic signed [ACC_W-1:0] sat_y;

  assign k_last = (k == IW'(N_INPUTS - 1));
  assign n_last = (neuron == NW'(N_NEURONS - 1));

  bias_relu_sat #(.RELU(RELU)) u_brs (
    .acc  (mac_acc),
    .bias (bias_data),
    .y    (sat_y)
  );

  always_comb begin
    state_n  = state;
    k_n      = k;
    neuron_n = neuron;
    w_n      = w;
    d_n      = d;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n  = S_FEED;
          k_n      = '0;
          neuron_n = '0;
          w_n      = '0;
        end
      end
      S_FEED: begin
        if (k_last) begin
          state_n = S_DRAIN;
          d_n     = '0;
        end else begin
          k_n = k + 1'b1;
          w_n = w + 1'b1;
        end
      end
      S_DRAIN: begin
        // last term reaches mac_acc MAC_LAT+1 cycles after the final address
        if (d == DW'(MAC_LAT)) begin
          state_n = S_OUT;
          capture = 1'b1;
        end else begin
          d_n = d + 1'b1;
        end
      end
      S_OUT: begin
        if (result_ready) begin
          if (n_last) begin
            state_n = S_DONE;
          end else begin
            state_n  = S_FEED;
            neuron_n = neuron + 1'b1;
            k_n      = '0;
            // weights are laid out neuron-major, so the next row starts right after this one
            w_n      = w + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      k         <= '0;
      neuron    <= '0;
      w         <= '0;
      d         <= '0;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      result    <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      neuron    <= neuron_n;
      w         <= w_n;
      d         <= d_n;
      // strobes trail the address by one cycle to line up with the sync-read memories
      mac_en    <= (state == S_FEED);
      mac_first <= (state == S_FEED) && (k == '0);
      if (capture) begin
        result <= sat_y;
      end
    end
  end

  assign busy         = (state == S_FEED) || (state == S_DRAIN) || (state == S_OUT);
  assign done         = (state == S_DONE);
  assign result_valid = (state == S_OUT);
  assign in_addr      = k;
  assign w_addr       = w;
  assign bias_addr    = neuron;
  assign neuron_idx   = neuron;

endmodule
